// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder between NREQ requesters, with a
// single registered response slot. Optional subtract support under ADDER_ARB_SUB_EN.
module adder_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 64,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [NREQ-1:0]         req_cin,
  input  logic [NREQ-1:0]         req_sub,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [WIDTH-1:0]        rsp_sum,
  output logic                    rsp_cout,
  output logic                    rsp_ovf
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [IDW-1:0]    last_q, last_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]  rsp_sum_q, rsp_sum_d;
  logic              rsp_cout_q, rsp_cout_d;
  logic              rsp_ovf_q, rsp_ovf_d;

  logic [WIDTH-1:0]  a_arr [NREQ];
  logic [WIDTH-1:0]  b_arr [NREQ];
  logic [IDW-1:0]    win_idx;
  logic              win_found;
  logic              can_accept;
  logic              accept;
  logic [WIDTH-1:0]  b_eff;
  logic              c_eff;
  logic [WIDTH+1:0]  add_res;

  // Returns {ovf, cout, sum}; overflow is judged on the operands actually added.
  function automatic logic [WIDTH+1:0] add_op(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic             c);
    logic [WIDTH:0] s;
    logic           ovf;
    s   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    ovf = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    return {ovf, s};
  endfunction

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = req_a[i*WIDTH +: WIDTH];
      b_arr[i] = req_b[i*WIDTH +: WIDTH];
    end
  end

  // Search from last+1 upward, wrapping, so the previous winner has lowest priority.
  always_comb begin
    int             idx;
    logic [IDW-1:0] idx_l;
    idx       = 0;
    idx_l     = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_l = IDW'(idx);
      if (!win_found && req_valid[idx_l]) begin
        win_found = 1'b1;
        win_idx   = idx_l;
      end
    end
  end

  always_comb begin
    can_accept = ((state_q == EMPTY) || rsp_ready) && !rst;
    req_ready  = '0;
    if (win_found && can_accept) req_ready[win_idx] = 1'b1;
    accept = win_found && can_accept;
  end

  always_comb begin
    b_eff = b_arr[win_idx];
    c_eff = req_cin[win_idx];
`ifdef ADDER_ARB_SUB_EN
    if (req_sub[win_idx]) begin
      b_eff = ~b_arr[win_idx];
      c_eff = 1'b1;
    end
`endif
    add_res = add_op(a_arr[win_idx], b_eff, c_eff);
  end

`ifndef ADDER_ARB_SUB_EN
  logic sub_unused;
  assign sub_unused = ^req_sub;
`endif

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    rsp_id_d   = rsp_id_q;
    rsp_sum_d  = rsp_sum_q;
    rsp_cout_d = rsp_cout_q;
    rsp_ovf_d  = rsp_ovf_q;
    if (accept) begin
      state_d    = FULL;
      last_d     = win_idx;
      rsp_id_d   = win_idx;
      rsp_sum_d  = add_res[WIDTH-1:0];
      rsp_cout_d = add_res[WIDTH];
      rsp_ovf_d  = add_res[WIDTH+1];
    end else if ((state_q == FULL) && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      last_q     <= IDW'(NREQ - 1);
      rsp_id_q   <= '0;
      rsp_sum_q  <= '0;
      rsp_cout_q <= 1'b0;
      rsp_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      rsp_id_q   <= rsp_id_d;
      rsp_sum_q  <= rsp_sum_d;
      rsp_cout_q <= rsp_cout_d;
      rsp_ovf_q  <= rsp_ovf_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: vector table plus scoreboard of expected
// responses, with hand-written reset, round-robin, backpressure and reset-mid-op sequences.
module tb_adder_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 64;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*W-1:0]   req_a, req_b;
  logic [NREQ-1:0]     req_cin, req_sub;
  logic                rsp_valid, rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [W-1:0]        rsp_sum;
  logic                rsp_cout, rsp_ovf;

  logic [W-1:0] a_arr [NREQ];
  logic [W-1:0] b_arr [NREQ];

  typedef struct {
    logic [IDW-1:0] id;
    logic [W-1:0]   sum;
    logic           cout;
    logic           ovf;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  exp_t            sb [$];
  int              grants [$];
  logic [NREQ-1:0] last_rr;
  int              n_cmp = 0;
  int              n_err = 0;
  vec_t            tbl [8];

  adder_arbiter #(.NREQ(NREQ), .WIDTH(W), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_sub(req_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = a_arr[i];
      req_b[i*W +: W] = b_arr[i];
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: signed sum at W+2 bits gives overflow independently of the MSB rule.
  function automatic exp_t model(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t                r;
    logic [W-1:0]        bb;
    logic                c;
    logic [W:0]          u;
    logic signed [W+1:0] s;
    bb = b;
    c  = cin;
`ifdef ADDER_ARB_SUB_EN
    if (sub) begin
      bb = ~b;
      c  = 1'b1;
    end
`endif
    u = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
    s = $signed({{2{a[W-1]}}, a}) + $signed({{2{bb[W-1]}}, bb}) + $signed({{(W+1){1'b0}}, c});
    r.id   = IDW'(id);
    r.sum  = u[W-1:0];
    r.cout = u[W];
    r.ovf  = (s > $signed({3'b000, {(W-1){1'b1}}})) || (s < -$signed({3'b000, 1'b1, {(W-1){1'b0}}}));
    return r;
  endfunction

  // One clock: settle, consume a response if handed off, log a grant, then cross the edge.
  task automatic cycle();
    exp_t e;
    int   w;
    #1;
    last_rr = req_ready;
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL sb_underflow: got response id %0d expected none", rsp_id);
      end else begin
        e = sb.pop_front();
        chk("rsp_id",   W'(rsp_id), W'(e.id));
        chk("rsp_sum",  rsp_sum,    e.sum);
        chk("rsp_cout", W'(rsp_cout), W'(e.cout));
        chk("rsp_ovf",  W'(rsp_ovf),  W'(e.ovf));
      end
    end
    if (|req_ready) begin
      w = 0;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) w = i;
      chk("ready_onehot", W'($countones(req_ready)), W'(1));
      chk("ready_needs_valid", W'(req_ready & ~req_valid), '0);
      sb.push_back(model(w, a_arr[w], b_arr[w], req_cin[w], req_sub[w]));
      grants.push_back(w);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{a:64'd1, b:64'd2, cin:1'b0, sub:1'b0, sum:64'd3, cout:1'b0, ovf:1'b0};
    tbl[1] = '{a:64'hFFFF_FFFF_FFFF_FFFF, b:64'd1, cin:1'b0, sub:1'b0, sum:64'd0, cout:1'b1, ovf:1'b0};
    tbl[2] = '{a:64'h7FFF_FFFF_FFFF_FFFF, b:64'd1, cin:1'b0, sub:1'b0,
               sum:64'h8000_0000_0000_0000, cout:1'b0, ovf:1'b1};
    tbl[3] = '{a:64'h8000_0000_0000_0000, b:64'h8000_0000_0000_0000, cin:1'b0, sub:1'b0,
               sum:64'd0, cout:1'b1, ovf:1'b1};
    tbl[4] = '{a:64'd5, b:64'd7, cin:1'b1, sub:1'b0, sum:64'd13, cout:1'b0, ovf:1'b0};
    tbl[6] = '{a:64'hFFFF_FFFF_FFFF_FFFF, b:64'hFFFF_FFFF_FFFF_FFFF, cin:1'b1, sub:1'b0,
               sum:64'hFFFF_FFFF_FFFF_FFFF, cout:1'b1, ovf:1'b0};
`ifdef ADDER_ARB_SUB_EN
    tbl[5] = '{a:64'd5, b:64'd7, cin:1'b0, sub:1'b1, sum:64'hFFFF_FFFF_FFFF_FFFE, cout:1'b0, ovf:1'b0};
    tbl[7] = '{a:64'd7, b:64'd5, cin:1'b1, sub:1'b1, sum:64'd2, cout:1'b1, ovf:1'b0};
`else
    tbl[5] = '{a:64'd5, b:64'd7, cin:1'b0, sub:1'b1, sum:64'd12, cout:1'b0, ovf:1'b0};
    tbl[7] = '{a:64'd7, b:64'd5, cin:1'b1, sub:1'b1, sum:64'd13, cout:1'b0, ovf:1'b0};
`endif

    // Reset with every requester valid
    rst       = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '1;
    req_cin   = '0;
    req_sub   = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = W'(100 * (i + 1));
      b_arr[i] = W'(i + 7);
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("reset_req_ready", W'(req_ready), '0);
      chk("reset_rsp_valid", W'(rsp_valid), '0);
      @(posedge clk);
      #1;
    end
    chk("reset_rsp_id",   W'(rsp_id), '0);
    chk("reset_rsp_sum",  rsp_sum, '0);
    chk("reset_rsp_cout", W'(rsp_cout), '0);
    chk("reset_rsp_ovf",  W'(rsp_ovf), '0);

    // Round robin with all four valid
    rst = 1'b0;
    req_cin[1] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (c == 0) chk("first_grant_req0", W'(last_rr), W'(4'b0001));
    end
    for (int k = 0; k < 6; k++) begin
      if (k < grants.size()) chk($sformatf("rr_order_%0d", k), W'(grants[k]), W'(k % 4));
      else chk($sformatf("rr_order_%0d_missing", k), W'(grants.size()), W'(k + 1));
    end
    req_valid = '0;
    req_cin   = '0;
    cycle();
    chk("drained_rr", W'(rsp_valid), '0);

    // Backpressure: requester 2 wraps to zero and is held while requester 3 waits
    a_arr[2]  = 64'hFFFF_FFFF_FFFF_FFFF;
    b_arr[2]  = 64'd1;
    req_valid = 4'b0100;
    cycle();
    chk("bp_grant2", W'(last_rr), W'(4'b0100));
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    a_arr[3]  = 64'd10;
    b_arr[3]  = 64'd20;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_rsp_valid", W'(rsp_valid), W'(1));
      chk("bp_rsp_id",    W'(rsp_id), W'(2));
      chk("bp_rsp_sum",   rsp_sum, '0);
      chk("bp_rsp_cout",  W'(rsp_cout), W'(1));
      chk("bp_rsp_ovf",   W'(rsp_ovf), '0);
      chk("bp_req_ready", W'(req_ready), '0);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    cycle();
    chk("bp_release_grant3", W'(last_rr), W'(4'b1000));
    chk("bp_b2b_id3", W'(rsp_id), W'(3));
    chk("bp_b2b_valid", W'(rsp_valid), W'(1));
    req_valid = '0;
    cycle();

    // Single requester granted every cycle
    req_valid = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      a_arr[3] = W'(c * 1000 + 1);
      cycle();
      chk("single_grant3", W'(last_rr), W'(4'b1000));
    end
    req_valid = '0;
    cycle();

    // Vector table
    for (int k = 0; k < 8; k++) begin
      int r;
      r = k % 4;
      a_arr[r]   = tbl[k].a;
      b_arr[r]   = tbl[k].b;
      req_cin    = '0;
      req_sub    = '0;
      req_cin[r] = tbl[k].cin;
      req_sub[r] = tbl[k].sub;
      req_valid  = 4'(1 << r);
      cycle();
      chk($sformatf("tbl%0d_grant", k), W'(last_rr), W'(1 << r));
      chk($sformatf("tbl%0d_id", k),    W'(rsp_id), W'(r));
      chk($sformatf("tbl%0d_sum", k),   rsp_sum, tbl[k].sum);
      chk($sformatf("tbl%0d_cout", k),  W'(rsp_cout), W'(tbl[k].cout));
      chk($sformatf("tbl%0d_ovf", k),   W'(rsp_ovf), W'(tbl[k].ovf));
    end
    req_valid = '0;
    req_cin   = '0;
    req_sub   = '0;
    cycle();

    // Reset while FULL and stalled, after requester 1 won last
    a_arr[1]  = 64'd3;
    b_arr[1]  = 64'd4;
    req_valid = 4'b0010;
    cycle();
    chk("rmid_grant1", W'(last_rr), W'(4'b0010));
    rsp_ready = 1'b0;
    req_valid = '1;
    rst       = 1'b1;
    #1;
    chk("rmid_ready_in_reset", W'(req_ready), '0);
    @(posedge clk);
    #1;
    sb.delete();
    chk("rmid_rsp_valid", W'(rsp_valid), '0);
    rst       = 1'b0;
    rsp_ready = 1'b1;
    cycle();
    chk("rmid_first_grant0", W'(last_rr), W'(4'b0001));
    req_valid = '0;
    cycle();
    chk("end_sb_empty", W'(sb.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Shares one 64-bit adder datapath between NREQ requesters (ALU, address generation, branch-target units) in the RISC-V core. Each cycle a round-robin arbiter grants at most one valid request. The granted operands pass through the adder, and the result is captured in a single registered response slot with valid/ready backpressure. Throughput is one add per cycle, latency is one cycle, and every requester is guaranteed to be served.

## Interface
- NREQ, 4: number of requesters; 2..8.
- WIDTH, 64: operand and sum width.
- IDW, $clog2(NREQ): width of rsp_id.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  request valid; bit i belongs to requester i.
- req_ready  out  NREQ  grant/accept; one-hot or zero.
- req_a  in  NREQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B, same packing as req_a.
- req_cin  in  NREQ  carry-in.
- req_sub  in  NREQ  subtract select; only honoured with ADDER_ARB_SUB_EN.
- rsp_valid  out  1  response slot holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_sum  out  WIDTH  sum.
- rsp_cout  out  1  carry-out from bit WIDTH-1.
- rsp_ovf  out  1  signed overflow.

## Operation
- Response slot states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- can_accept = EMPTY, or (FULL and rsp_ready).
- Arbitration is combinational round-robin.
  - Search starts at (last+1) mod NREQ and wraps.
  - The first i with req_valid[i] wins, but only if can_accept.
  - req_ready = one-hot of the winner, otherwise all zero.
- Accept happens when req_valid[i] & req_ready[i] at the clock edge. On accept:
  - the slot captures rsp_id=i, rsp_sum, rsp_cout, rsp_ovf; the state becomes FULL;
  - last is set to i.
- Arithmetic:
  - b' = req_b, c = req_cin.
  - {rsp_cout, rsp_sum} = a + b' + c, computed at WIDTH+1 bits.
  - rsp_ovf = (a[W-1]==b'[W-1]) & (rsp_sum[W-1]!=a[W-1]).
- Drain: FULL & rsp_ready & no accept -> EMPTY. FULL & rsp_ready & accept -> stays FULL with the new result (back-to-back).
- FULL & !rsp_ready: rsp_* outputs stay stable; req_ready is all zero; last is unchanged.
- Requesters must not make req_valid depend on req_ready. req_ready may depend on req_valid combinationally.
- Once asserted, a request holds valid and its operands until accepted.
- Fairness: a continuously valid requester is granted within NREQ accepts.

## Timing
- Reset values: rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0, last=NREQ-1, so requester 0 has first priority.
- req_ready is 0 during reset.
- Latency: accept at edge T -> rsp_valid=1 and the result visible after edge T. That is 1 cycle.
- Throughput: 1 result per cycle while rsp_ready=1.
- rsp_ready is sampled only at edges where rsp_valid=1. rsp_ready while EMPTY is ignored.
- Reset mid-operation: a held result is discarded (rsp_valid=0 the cycle after the reset edge), and last returns to NREQ-1. No accept occurs on a reset edge.
- Single requester: granted every cycle while can_accept.
- Wrap-around: last=NREQ-1 searches from 0.

## Configuration
- ADDER_ARB_SUB_EN defined:
  - req_sub[i]=1 sets b' = ~req_b and forces c=1, so the result is a-b and req_cin is ignored;
  - rsp_cout=1 means no borrow;
  - rsp_ovf uses the inverted b'.
- ADDER_ARB_SUB_EN undefined: req_sub is ignored, and every operation is a + b + cin. The port stays present, so the interface is unchanged.

## Test plan
- Reset check: hold rst for 3 cycles with all valids high -> req_ready=0 and rsp_valid=0 throughout. First grant after release goes to requester 0.
- All 4 requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1. rsp_id matches that order one cycle later.
- Backpressure: requester 2 sends a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0; hold rsp_ready=0 for 5 cycles while requester 3 is valid. Required response:
  - sum=0, cout=1, ovf=0, rsp_id=2, held stable for all 5 cycles;
  - req_ready=0 during the hold;
  - when rsp_ready rises, requester 3 is accepted in that same cycle.
- Overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> sum=0x8000_0000_0000_0000, ovf=1, cout=0.
- With ADDER_ARB_SUB_EN: sub=1, a=5, b=7, cin=0 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0. Without the macro, the same stimulus gives sum=12.
- Reset mid-operation: assert rst while FULL with rsp_ready=0 -> rsp_valid=0 next cycle. Requester 0 is then granted first even if last was 1.
